stream_framing_monitor: RTL and testbench
=========================================

// Module: stream_framing_monitor
// PURPOSE
//  Inline Avalon-ST framing checker placed directly downstream of the delay-line fifo.
//  Registers the delayed stream through to the next stage with 1 cycle of latency.
//  Tracks packet state and packet length, and counts framing errors (orphan beat, duplicate sop, oversize).
//  Exposes counters to the CSR block. There is no backpressure; the stream is push-only.
// PARAMETERS
//  BYTES_PER_BEAT  8      bytes per data beat; must equal the width of avln_st.data / 8
//  LEN_W           16     width of the byte-length accumulator and of last_len
//  MAX_BYTES       9600   packets longer than this raise err_too_long
//  CNT_W           32     width of pkt_count
//  ERR_W           16     width of each error counter
// PORTS
//  sys_clk         in   1           system clock
//  reset_n         in   1           asynchronous active-low reset
//  in              in   avln_st     input stream (data, sop, eop, empty, valid)
//  out             out  avln_st     registered output stream
//  stats_clr       in   1           synchronous clear of all counters
//  in_pkt          out  1           1 while between an accepted sop and its eop
//  pkt_count       out  CNT_W       completed packets; wraps at 2^CNT_W
//  last_len        out  LEN_W       byte length of the most recent completed packet
//  last_len_vld    out  1           1-cycle pulse when last_len updates
//  err_orphan      out  ERR_W       valid beats outside a packet without sop; saturating
//  err_dup_sop     out  ERR_W       sop seen while already in a packet; saturating
//  err_too_long    out  ERR_W       packets exceeding MAX_BYTES; saturating
// BEHAVIOUR
//  Reset (async assert, sync release): out is all-zero. State=IDLE. All counters, last_len,
//   last_len_vld and in_pkt are 0.
//  Only beats with in.valid=1 are evaluated. A beat with valid=0 changes no state; out copies it.
//  Beat bytes: BYTES_PER_BEAT on a non-eop beat; BYTES_PER_BEAT - in.empty on an eop beat.
//  FSM IDLE:
//   - sop&eop: pkt_count++, last_len=beat bytes, pulse last_len_vld; stay in IDLE.
//   - sop&!eop: len=beat bytes; go to INPKT.
//   - !sop: err_orphan++. A lone eop is also an orphan. Stay in IDLE.
//  FSM INPKT:
//   - sop (with or without eop): err_dup_sop++. The old packet is abandoned and not counted.
//     Then the beat is handled as in IDLE, restarting len.
//   - eop: last_len=len+beat bytes, pkt_count++, pulse last_len_vld; go to IDLE.
//   - otherwise: len+=beat bytes.
//  Length arithmetic: len saturates at 2^LEN_W-1.
//   - Oversize: err_too_long++ once per packet, on the first beat where len exceeds MAX_BYTES.
//     A per-packet flag suppresses repeats. The packet is still counted at eop.
//  in_pkt: 1 when state=INPKT, registered (aligned with out).
//  Latency: out is in delayed by exactly 1 cycle. Counter and last_len updates are visible
//   on the same cycle the beat appears on out.
//  Counters: error counters saturate at all-ones. pkt_count wraps.
//  stats_clr: zeroes all counters and last_len next cycle. It wins over any same-cycle
//   increment. FSM state and len are NOT affected.
//  Reset mid-packet: the FSM returns to IDLE. Trailing beats of the cut packet count as orphans.
// CONFIGURATION
//  FRAMING_FILTER_EN defined:
//   - Orphan beats are suppressed at out: valid, sop and eop are forced to 0 and data passes.
//   - A dup-sop beat is forwarded with sop=1 unchanged.
//  FRAMING_FILTER_EN undefined: out is a pure 1-cycle copy of in. Counters behave identically.
// TESTING
//  - Reset: hold reset_n=0 with random in -> out=0 and all counters 0. After release the
//    first valid sop is accepted.
//  - 3-beat packet (sop, mid, eop with empty=3) -> pkt_count=1, last_len=21,
//    last_len_vld one pulse, out matches in delayed by 1.
//  - Lone eop beat then single-beat sop&eop empty=0 -> err_orphan=1, pkt_count=1, last_len=8.
//    With FRAMING_FILTER_EN the orphan shows out.valid=0.
//  - sop, mid, sop, eop -> err_dup_sop=1, pkt_count=1, last_len=16 (restart).
//  - 1201-beat packet (9608 B) -> err_too_long=1, only once, pkt_count=1, last_len=9608.
//  - err_orphan driven to 0xFFFF plus 3 orphans -> stays 0xFFFF. Then stats_clr together with
//    an eop -> pkt_count=0 next cycle.

Source files
------------

// File: rtl/stream_framing_monitor.sv
// Inline Avalon-ST framing checker: registers the stream through with 1 cycle of latency and counts framing errors.
// Build option FRAMING_FILTER_EN: orphan beats are stripped of valid/sop/eop at the output.
package stream_framing_monitor_pkg;
   localparam int unsigned AVLN_BYTES   = 8;
   localparam int unsigned AVLN_DATA_W  = AVLN_BYTES * 8;
   localparam int unsigned AVLN_EMPTY_W = $clog2(AVLN_BYTES);

   typedef struct packed {
      logic [AVLN_DATA_W-1:0]  data;
      logic                    sop;
      logic                    eop;
      logic [AVLN_EMPTY_W-1:0] empty;
      logic                    valid;
   } avln_st;
endpackage

module stream_framing_monitor
   import stream_framing_monitor_pkg::*;
#(
   parameter int unsigned BYTES_PER_BEAT = AVLN_BYTES,
   parameter int unsigned LEN_W          = 16,
   parameter int unsigned MAX_BYTES      = 9600,
   parameter int unsigned CNT_W          = 32,
   parameter int unsigned ERR_W          = 16
) (
   input  logic             sys_clk,
   input  logic             reset_n,
   input  avln_st           in,
   output avln_st           out,
   input  logic             stats_clr,
   output logic             in_pkt,
   output logic [CNT_W-1:0] pkt_count,
   output logic [LEN_W-1:0] last_len,
   output logic             last_len_vld,
   output logic [ERR_W-1:0] err_orphan,
   output logic [ERR_W-1:0] err_dup_sop,
   output logic [ERR_W-1:0] err_too_long
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_INPKT = 1'b1;

   logic [0:0]       state, state_nxt;
   logic [LEN_W-1:0] len, len_nxt;
   logic             oversize, oversize_nxt;
   logic [LEN_W-1:0] beat_bytes;
   logic [LEN_W:0]   len_sum;
   logic [LEN_W-1:0] len_sat;
   logic [LEN_W-1:0] acc_len;
   logic             accept, flag_cur;
   logic             inc_pkt, inc_orphan, inc_dup, inc_long;
   avln_st           out_nxt;

   // Bytes carried by this beat and the saturating running length
   always_comb begin
      beat_bytes = LEN_W'(BYTES_PER_BEAT) - (in.eop ? LEN_W'(in.empty) : '0);
      len_sum    = {1'b0, len} + {1'b0, beat_bytes};
      len_sat    = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
   end

   // Next-state, length tracking and counter increment decode
   always_comb begin
      state_nxt    = state;
      len_nxt      = len;
      oversize_nxt = oversize;
      accept       = 1'b0;
      flag_cur     = oversize;
      acc_len      = len_sat;
      inc_pkt      = 1'b0;
      inc_orphan   = 1'b0;
      inc_dup      = 1'b0;
      inc_long     = 1'b0;
      out_nxt      = in;

      case (state)
         ST_IDLE: begin
            if (in.valid) begin
               if (in.sop) accept = 1'b1;
               else        inc_orphan = 1'b1;
            end
         end
         ST_INPKT: begin
            if (in.valid) begin
               accept  = 1'b1;
               inc_dup = in.sop;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      // A sop always restarts the length and the oversize flag, abandoning any open packet
      if (accept) begin
         if (in.sop) begin
            acc_len  = beat_bytes;
            flag_cur = 1'b0;
         end
         len_nxt      = acc_len;
         inc_long     = !flag_cur && (acc_len > LEN_W'(MAX_BYTES));
         oversize_nxt = flag_cur || inc_long;
         if (in.eop) begin
            inc_pkt   = 1'b1;
            state_nxt = ST_IDLE;
         end else begin
            state_nxt = ST_INPKT;
         end
      end

`ifdef FRAMING_FILTER_EN
      if (inc_orphan) begin
         out_nxt.valid = 1'b0;
         out_nxt.sop   = 1'b0;
         out_nxt.eop   = 1'b0;
      end
`endif
   end

   // FSM state, length and registered outputs; stats_clr leaves state and len alone
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         len          <= '0;
         oversize     <= 1'b0;
         out          <= '0;
         in_pkt       <= 1'b0;
         pkt_count    <= '0;
         last_len     <= '0;
         last_len_vld <= 1'b0;
         err_orphan   <= '0;
         err_dup_sop  <= '0;
         err_too_long <= '0;
      end else begin
         state    <= state_nxt;
         len      <= len_nxt;
         oversize <= oversize_nxt;
         out      <= out_nxt;
         in_pkt   <= (state_nxt == ST_INPKT);
         if (stats_clr) begin
            pkt_count    <= '0;
            last_len     <= '0;
            last_len_vld <= 1'b0;
            err_orphan   <= '0;
            err_dup_sop  <= '0;
            err_too_long <= '0;
         end else begin
            last_len_vld <= inc_pkt;
            if (inc_pkt) begin
               pkt_count <= pkt_count + CNT_W'(1);
               last_len  <= acc_len;
            end
            if (inc_orphan && (err_orphan != '1))   err_orphan   <= err_orphan + ERR_W'(1);
            if (inc_dup && (err_dup_sop != '1))     err_dup_sop  <= err_dup_sop + ERR_W'(1);
            if (inc_long && (err_too_long != '1))   err_too_long <= err_too_long + ERR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_stream_framing_monitor.sv
// Scoreboard bench for stream_framing_monitor: randomized and directed beats against a packet-level reference model.
module tb_stream_framing_monitor;
   import stream_framing_monitor_pkg::*;

   localparam int MAX_BYTES = 9600;

   typedef struct packed {
      avln_st      out;
      logic        in_pkt;
      logic [31:0] pkt_count;
      logic [15:0] last_len;
      logic        last_len_vld;
      logic [15:0] err_orphan;
      logic [15:0] err_dup_sop;
      logic [15:0] err_too_long;
   } rec_t;

   logic        sys_clk = 1'b0;
   logic        reset_n = 1'b0;
   avln_st      in = '0;
   avln_st      out;
   logic        stats_clr = 1'b0;
   logic        in_pkt;
   logic [31:0] pkt_count;
   logic [15:0] last_len;
   logic        last_len_vld;
   logic [15:0] err_orphan, err_dup_sop, err_too_long;

   int checks = 0;
   int failures = 0;
   rec_t exp_q[$];

   // Reference model state: packet-level view of the stream
   bit          m_in_pkt;
   int          m_len;
   bit          m_flagged;
   logic [31:0] m_pkts;
   logic [15:0] m_last, m_orph, m_dup, m_long;

   stream_framing_monitor dut (
      .sys_clk(sys_clk), .reset_n(reset_n), .in(in), .out(out), .stats_clr(stats_clr),
      .in_pkt(in_pkt), .pkt_count(pkt_count), .last_len(last_len), .last_len_vld(last_len_vld),
      .err_orphan(err_orphan), .err_dup_sop(err_dup_sop), .err_too_long(err_too_long)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic logic [15:0] sat_inc(input logic [15:0] x);
      return (x == 16'hFFFF) ? x : x + 16'd1;
   endfunction

   function automatic rec_t model_step(input avln_st b, input logic clr, input logic rst_n_v);
      rec_t r;
      bit   orphan;
      int   bytes;
      r = '0;
      if (!rst_n_v) begin
         m_in_pkt = 0; m_len = 0; m_flagged = 0;
         m_pkts = '0; m_last = '0; m_orph = '0; m_dup = '0; m_long = '0;
         return r;
      end
      r.out = b;
      if (b.valid) begin
         bytes  = b.eop ? 8 - int'(b.empty) : 8;
         orphan = !b.sop && !m_in_pkt;
         if (orphan) begin
            m_orph = sat_inc(m_orph);
`ifdef FRAMING_FILTER_EN
            r.out.valid = 1'b0; r.out.sop = 1'b0; r.out.eop = 1'b0;
`endif
         end else begin
            if (b.sop) begin
               if (m_in_pkt) m_dup = sat_inc(m_dup);
               m_len = bytes;
               m_flagged = 0;
            end else begin
               m_len = (m_len + bytes > 65535) ? 65535 : m_len + bytes;
            end
            if (m_len > MAX_BYTES && !m_flagged) begin
               m_long = sat_inc(m_long);
               m_flagged = 1;
            end
            if (b.eop) begin
               m_pkts = m_pkts + 32'd1;
               m_last = 16'(m_len);
               r.last_len_vld = 1'b1;
               m_in_pkt = 0;
            end else begin
               m_in_pkt = 1;
            end
         end
      end
      if (clr) begin
         m_pkts = '0; m_last = '0; m_orph = '0; m_dup = '0; m_long = '0;
         r.last_len_vld = 1'b0;
      end
      r.in_pkt = m_in_pkt;
      r.pkt_count = m_pkts;
      r.last_len = m_last;
      r.err_orphan = m_orph;
      r.err_dup_sop = m_dup;
      r.err_too_long = m_long;
      return r;
   endfunction

   task automatic beat(input logic v, input logic s, input logic e, input logic [2:0] emp,
                       input logic clr, input logic rst_n_v);
      avln_st b;
      @(negedge sys_clk);
      b.data  = {$urandom, $urandom};
      b.valid = v;
      b.sop   = s;
      b.eop   = e;
      b.empty = emp;
      in        = b;
      stats_clr = clr;
      reset_n   = rst_n_v;
      exp_q.push_back(model_step(b, clr, rst_n_v));
   endtask

   task automatic idle();
      beat(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
   endtask

   // Direct check against a literal, taken once the last driven beat has been registered
   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic settle();
      @(posedge sys_clk);
      #2;
   endtask

   // Monitor: one registered result per cycle, popped after the active edge
   initial begin
      rec_t e, a;
      forever begin
         @(posedge sys_clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.out = out; a.in_pkt = in_pkt; a.pkt_count = pkt_count; a.last_len = last_len;
            a.last_len_vld = last_len_vld; a.err_orphan = err_orphan;
            a.err_dup_sop = err_dup_sop; a.err_too_long = err_too_long;
            checks++;
            if (a !== e) begin
               failures++;
               $display("FAIL sb t=%0t actual out=%h in_pkt=%b pkt=%0d len=%0d vld=%b orph=%0h dup=%0h long=%0h required out=%h in_pkt=%b pkt=%0d len=%0d vld=%b orph=%0h dup=%0h long=%0h",
                        $time, a.out, a.in_pkt, a.pkt_count, a.last_len, a.last_len_vld, a.err_orphan,
                        a.err_dup_sop, a.err_too_long, e.out, e.in_pkt, e.pkt_count, e.last_len,
                        e.last_len_vld, e.err_orphan, e.err_dup_sop, e.err_too_long);
            end
         end
      end
   end

   initial begin
      int budget;
      // Reset held with random valid traffic
      for (int i = 0; i < 4; i++)
         beat(1'b1, 1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 1'b0);
      settle();
      check_val("rst_out", 32'(out.valid), 32'd0);
      check_val("rst_orphan", 32'(err_orphan), 32'd0);
      idle();

      // 3-beat packet, 21 bytes
      beat(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
      beat(1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1);
      beat(1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1);
      settle();
      check_val("basic_vld", 32'(last_len_vld), 32'd1);
      check_val("basic_pkt", pkt_count, 32'd1);
      check_val("basic_len", 32'(last_len), 32'd21);
      idle();

      // Lone eop orphan, then single-beat packet
      beat(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
      beat(1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1);
      beat(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1);
      settle();
      check_val("orph_cnt", 32'(err_orphan), 32'd1);
      check_val("orph_pkt", pkt_count, 32'd1);
      check_val("orph_len", 32'(last_len), 32'd8);
      idle();

      // Duplicate sop restarts the length
      beat(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
      beat(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
      beat(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
      beat(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
      beat(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
      settle();
      check_val("dup_cnt", 32'(err_dup_sop), 32'd1);
      check_val("dup_pkt", pkt_count, 32'd1);
      check_val("dup_len", 32'(last_len), 32'd16);
      idle();

      // 1201-beat oversize packet, 9608 bytes
      beat(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
      beat(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
      for (int i = 0; i < 1199; i++) beat(1'b1, 1'b0, 1'b0, 3'($urandom), 1'b0, 1'b1);
      beat(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
      settle();
      check_val("long_cnt", 32'(err_too_long), 32'd1);
      check_val("long_pkt", pkt_count, 32'd1);
      check_val("long_len", 32'(last_len), 32'd9608);
      idle();

      // Reset mid-packet: trailing beats become orphans
      beat(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
      beat(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
      beat(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      idle();
      beat(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
      beat(1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1);
      settle();
      check_val("cut_orph", 32'(err_orphan), 32'd2);

      // Randomized traffic
      for (int i = 0; i < 3000; i++)
         beat(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 2), 1'($urandom_range(0, 3) == 0),
              3'($urandom), 1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 499) != 0));
      idle();

      // Orphan counter saturation, then clear racing an eop
      beat(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
      for (int i = 0; i < 65535 + 3; i++) beat(1'b1, 1'b0, 1'($urandom), 3'($urandom), 1'b0, 1'b1);
      settle();
      check_val("orph_sat", 32'(err_orphan), 32'h0000FFFF);
      beat(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
      beat(1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1);
      settle();
      check_val("clr_pkt", pkt_count, 32'd0);
      check_val("clr_orph", 32'(err_orphan), 32'd0);
      idle();

      budget = 0;
      while (exp_q.size() > 0 && budget < 10) begin
         @(posedge sys_clk);
         budget++;
      end
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d pending required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
